// File: rtl/param_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// param_sync_fifo_if
//
// Purpose: groups the data-path and status signals of param_sync_fifo into
// one bundle. clk and res stay outside as plain module ports.
//
// Handshake semantics, used by both modports:
//   - wr_en is a write request. It is accepted at a rising edge only when
//     full was 0 before that edge. A request made while full is dropped and
//     sets overflow.
//   - rd_en is a read request. It is accepted at a rising edge only when
//     empty was 0 before that edge. A request made while empty is dropped
//     and sets underflow.
//   - full and empty therefore act as the "not ready" indications for the
//     write and read sides. Requesters must not assume acceptance while
//     they are high.
//
// Signals:
//   wr_en, wdata[WIDTH]       write request and data     (master -> slave)
//   rd_en                     read request / pop         (master -> slave)
//   clr_err                   clears sticky error flags  (master -> slave)
//   rdata[WIDTH]              read data                  (slave -> master)
//   full, empty               occupancy == DEPTH / == 0
//   almost_full, almost_empty threshold decodes of count
//   count[PTR_WIDTH+1]        current occupancy
//   overflow, underflow       sticky error flags
// ---------------------------------------------------------------------------
interface param_sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic               wr_en;
  logic [WIDTH-1:0]   wdata;
  logic               rd_en;
  logic               clr_err;
  logic [WIDTH-1:0]   rdata;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [PTR_WIDTH:0] count;
  logic               overflow;
  logic               underflow;

  // Requester side: drives the requests, observes data and status.
  modport master (
    output wr_en, wdata, rd_en, clr_err,
    input  rdata, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  // FIFO side: the reverse direction.
  modport slave (
    input  wr_en, wdata, rd_en, clr_err,
    output rdata, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
//
// Purpose: single-clock FIFO with a parameterised width and depth. It has
// almost-full and almost-empty thresholds and sticky overflow/underflow
// flags.
//
// Ports:
//   clk   rising-edge clock for all logic
//   res   synchronous active-high reset. It clears the pointers, count,
//         rdata and the error flags. Stored data is discarded logically,
//         but the array itself is not cleared.
//   bus   param_sync_fifo_if.slave. It carries wr_en/wdata, rd_en, clr_err,
//         rdata, full, empty, almost_full, almost_empty, count, overflow
//         and underflow.
//
// Build option:
//   PARAM_SYNC_FIFO_FWFT_EN
//     Undefined (default): rdata is registered. The word of an accepted
//       read appears one cycle after the rd_en edge and holds until the
//       next accepted read.
//     Defined: first-word-fall-through. rdata shows the head entry
//       whenever empty=0, and rd_en pops that entry. When the FIFO is
//       empty, rdata holds the last word that was popped.
//   Flags and count behave the same in both modes.
// ---------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                 clk,
  input  logic                 res,
  param_sync_fifo_if.slave     bus
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  // Thresholds resized once to the width of count, so each compare below
  // works on equal widths.
  localparam logic [PTR_WIDTH:0] DEPTH_C = DEPTH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AF_C    = AF_LEVEL[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] AE_C    = AE_LEVEL[PTR_WIDTH:0];

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0] count_q,  count_d;
  logic [WIDTH-1:0]   rdata_q,  rdata_d;
  logic               overflow_q,  overflow_d;
  logic               underflow_q, underflow_d;

  // ------------------------------------------------------------------------
  // Decodes of registered state
  // ------------------------------------------------------------------------
  logic [PTR_WIDTH-1:0] wr_addr;
  logic [PTR_WIDTH-1:0] rd_addr;
  logic                 full;
  logic                 empty;
  logic                 wr_acc;
  logic                 rd_acc;

  assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];

  // The pointer MSB is a wrap toggle. With equal addresses, differing
  // toggles mean the writer is a whole lap ahead (full). Identical pointers
  // mean the FIFO is empty.
  assign full  = (wr_addr == rd_addr) && (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Acceptance uses the flags as they were before the edge. A dropped
  // request never touches the storage or the pointers.
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Incrementing the full PTR_WIDTH+1 bit pointer wraps the address
    // from DEPTH-1 to 0 and flips the toggle bit in one step, because
    // DEPTH is a power of two.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      // In registered mode this is the output word. In FWFT mode it is the
      // value held once the FIFO runs empty.
      rdata_d  = mem_q[rd_addr];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // clr_err is applied first, so a new error in the same cycle wins.
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (bus.rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The storage array has no reset. Clearing the pointers is enough to
  // discard its contents. A write during reset is blocked by the guard.
  always_ff @(posedge clk) begin
    if (!res && wr_acc) begin
      mem_q[wr_addr] <= bus.wdata;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  // The head entry falls through combinationally. When empty, rdata shows
  // the last popped word, which is 0 after reset.
  assign bus.rdata = empty ? rdata_q : mem_q[rd_addr];
`else
  assign bus.rdata = rdata_q;
`endif

  // DEPTH_C documents the full-scale value of count. It is compared here
  // so that full stays tied to count == DEPTH in any reading of the code.
  logic unused_depth_chk;
  assign unused_depth_chk = (count_q == DEPTH_C) ^ full;

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;
  localparam int W = 8;
  localparam int D = 16;

  logic clk;
  logic res;

  param_sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_sync_fifo #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_rd;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Advance one rising edge, then settle 1 time unit before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    bus.wdata   = '0;
  endtask

  task automatic write_word(input logic [W-1:0] d);
    bus.wr_en = 1'b1;
    bus.wdata = d;
    tick();
    bus.wr_en = 1'b0;
    exp_q.push_back(d);
  endtask

  // Pops one word and checks it against the head of the expected queue.
  // The caller may have wr_en active at the same time.
  task automatic read_check(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    check(tag, 32'(bus.rdata), 32'(e));
    bus.rd_en = 1'b1;
    tick();
`else
    bus.rd_en = 1'b1;
    tick();
    check(tag, 32'(bus.rdata), 32'(e));
`endif
    last_rd = e;
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
    exp_q.delete();
    last_rd = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    do_reset();

    // Reset state
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_ae",    32'(bus.almost_empty), 32'd1);
    check("rst_full",  32'(bus.full), 32'd0);
    check("rst_af",    32'(bus.almost_full), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_ovf",   32'(bus.overflow), 32'd0);
    check("rst_unf",   32'(bus.underflow), 32'd0);

    // Fill with 0x00..0x0F. almost_full is expected from count 14,
    // almost_empty up to count 2, and full only at 16.
    for (int i = 0; i < D; i++) begin
      write_word(W'(i));
      check("fill_count", 32'(bus.count), 32'(i + 1));
      check("fill_af",    32'(bus.almost_full), 32'((i + 1) >= 14));
      check("fill_ae",    32'(bus.almost_empty), 32'((i + 1) <= 2));
      check("fill_full",  32'(bus.full), 32'((i + 1) == 16));
      check("fill_empty", 32'(bus.empty), 32'd0);
    end
    check("fill_ovf", 32'(bus.overflow), 32'd0);

    // A write while full is dropped and sets overflow.
    bus.wr_en = 1'b1;
    bus.wdata = 8'hAA;
    tick();
    bus.wr_en = 1'b0;
    check("ovf_flag",  32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_full",  32'(bus.full), 32'd1);

    // Drain all 16 words. The order must be preserved and 0xAA must not
    // appear.
    for (int i = 0; i < D; i++) begin
      read_check("drain_data");
    end
    bus.rd_en = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);

    // A read while empty sets underflow, and rdata holds the last word.
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("unf_flag",  32'(bus.underflow), 32'd1);
    check("unf_rdata", 32'(bus.rdata), 32'h0F);
    check("unf_count", 32'(bus.count), 32'd0);
    // A new error in the same cycle as clr_err wins.
    bus.rd_en = 1'b1;
    bus.clr_err = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("unf_clr_wins", 32'(bus.underflow), 32'd1);
    tick();
    bus.clr_err = 1'b0;
    check("unf_clr", 32'(bus.underflow), 32'd0);

    // Load count to 8, then read and write together for 40 cycles.
    for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i));
    check("mid_count", 32'(bus.count), 32'd8);
    for (int i = 0; i < 40; i++) begin
      bus.wr_en = 1'b1;
      bus.wdata = 8'h18 + 8'(i);
      exp_q.push_back(bus.wdata);
      read_check("stream_data");
      check("stream_count", 32'(bus.count), 32'd8);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check("stream_af", 32'(bus.almost_full), 32'd0);
    check("stream_ae", 32'(bus.almost_empty), 32'd0);

    // Write 3 words, then assert reset while wr_en is still high.
    write_word(8'hC0);
    write_word(8'hC1);
    write_word(8'hC2);
    bus.wr_en = 1'b1;
    bus.wdata = 8'hC3;
    res = 1'b1;
    tick();
    res = 1'b0;
    bus.wr_en = 1'b0;
    exp_q.delete();
    check("rst_mid_count", 32'(bus.count), 32'd0);
    check("rst_mid_empty", 32'(bus.empty), 32'd1);
    check("rst_mid_rdata", 32'(bus.rdata), 32'd0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("rst_mid_unf", 32'(bus.underflow), 32'd1);
    check("rst_mid_rdata2", 32'(bus.rdata), 32'd0);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;

    // Single word: in FWFT mode it is visible before any rd_en. In both
    // modes it is read back and the FIFO ends empty.
    write_word(8'h5A);
    check("single_empty", 32'(bus.empty), 32'd0);
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    check("fwft_head", 32'(bus.rdata), 32'h5A);
`endif
    read_check("single_data");
    bus.rd_en = 1'b0;
    check("single_empty_after", 32'(bus.empty), 32'd1);
    tick();
    check("single_hold", 32'(bus.rdata), 32'(last_rd));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
